cache_rd_arbiter: RTL and testbench

- Round-robin arbiter that shares the single AXI4-Lite read port of the direct-mapped cache between `N_REQ` requesters, e.g. instruction fetch and data load.
- Sits between the requester masters and the cache CPU-side AR/R channels.
- Accepts one read address and forwards it to the cache, then steers the cache's single read response back to the winning requester.
- Exactly one transaction is outstanding at any time.

---
 rtl/cache_rd_arbiter.sv | 126 ++++++++++++
 tb/tb_cache_rd_arbiter.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_rd_arbiter.sv
// cache_rd_arbiter: shares one AXI4-Lite read port among N_REQ requesters, one transaction in flight.
// Latency: m_ar_valid one cycle after the requester AR handshake; R channel passes through combinationally.
// Backpressure: low s_r_ready of the winner holds DATA; CACHE_RD_ARB_FIXED_PRIO_EN selects fixed priority.
module cache_rd_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int N_REQ  = 2,
  localparam int IDX_W = $clog2(N_REQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ*ADDR_W-1:0] s_ar_addr,
  input  logic [N_REQ-1:0]        s_ar_valid,
  output logic [N_REQ-1:0]        s_ar_ready,
  output logic [N_REQ*DATA_W-1:0] s_r_data,
  output logic [N_REQ*2-1:0]      s_r_resp,
  output logic [N_REQ-1:0]        s_r_valid,
  input  logic [N_REQ-1:0]        s_r_ready,
  output logic [ADDR_W-1:0]       m_ar_addr,
  output logic                    m_ar_valid,
  input  logic                    m_ar_ready,
  input  logic [DATA_W-1:0]       m_r_data,
  input  logic [1:0]              m_r_resp,
  input  logic                    m_r_valid,
  output logic                    m_r_ready,
  output logic [IDX_W-1:0]        grant_idx,
  output logic                    busy
);

  typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_DATA} state_t;

  state_t            state, state_nxt;
  logic              found;
  logic [IDX_W-1:0]  win;
  logic [ADDR_W-1:0] win_addr;
  int                cand;

`ifndef CACHE_RD_ARB_FIXED_PRIO_EN
  logic [IDX_W-1:0]  ptr;
`endif

  // Winner search: upward from ptr with wrap, or from index 0 in fixed-priority builds.
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = 0;
    for (int k = 0; k < N_REQ; k++) begin
`ifdef CACHE_RD_ARB_FIXED_PRIO_EN
      cand = k;
`else
      cand = int'(ptr) + k;
      if (cand >= N_REQ) cand = cand - N_REQ;
`endif
      if (!found && s_ar_valid[cand[IDX_W-1:0]]) begin
        found = 1'b1;
        win   = IDX_W'(cand);
      end
    end
  end

  always_comb begin
    win_addr = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (win == IDX_W'(k)) win_addr = s_ar_addr[k*ADDR_W +: ADDR_W];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    s_ar_ready = '0;
    s_r_valid  = '0;
    m_r_ready  = 1'b0;
    if (!rst) begin
      case (state)
        ST_IDLE: begin
          if (found) begin
            s_ar_ready[win] = 1'b1;
            state_nxt       = ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (m_ar_valid && m_ar_ready) state_nxt = ST_DATA;
        end
        ST_DATA: begin
          m_r_ready            = s_r_ready[grant_idx];
          s_r_valid[grant_idx] = m_r_valid;
          if (m_r_valid && s_r_ready[grant_idx]) state_nxt = ST_IDLE;
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m_ar_addr  <= '0;
      m_ar_valid <= 1'b0;
      grant_idx  <= '0;
`ifndef CACHE_RD_ARB_FIXED_PRIO_EN
      ptr        <= '0;
`endif
    end else begin
      if (state == ST_IDLE && found) begin
        m_ar_addr  <= win_addr;
        m_ar_valid <= 1'b1;
        grant_idx  <= win;
`ifndef CACHE_RD_ARB_FIXED_PRIO_EN
        ptr        <= (win == IDX_W'(N_REQ-1)) ? '0 : win + IDX_W'(1);
`endif
      end else if (state == ST_ADDR && m_ar_ready) begin
        m_ar_valid <= 1'b0;
      end
    end
  end

  // Response payload is broadcast; only the one-hot s_r_valid qualifies it.
  assign s_r_data = {N_REQ{m_r_data}};
  assign s_r_resp = {N_REQ{m_r_resp}};
  assign busy     = (state != ST_IDLE);

endmodule

// File: tb/tb_cache_rd_arbiter.sv
// Bench for cache_rd_arbiter (N_REQ=2): directed scenarios plus randomized traffic against an arbitration model.
`timescale 1ns/1ps
module tb_cache_rd_arbiter;
  localparam int N = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [63:0]   s_ar_addr;
  logic [1:0]    s_ar_valid, s_ar_ready, s_r_valid, s_r_ready;
  logic [63:0]   s_r_data;
  logic [3:0]    s_r_resp;
  logic [31:0]   m_ar_addr, m_r_data;
  logic          m_ar_valid, m_ar_ready, m_r_valid, m_r_ready, busy;
  logic [1:0]    m_r_resp;
  logic          grant_idx;

  int errors = 0;
  int checks = 0;
  int model_ptr = 0;

  cache_rd_arbiter #(.ADDR_W(32), .DATA_W(32), .N_REQ(N)) dut (
    .clk(clk), .rst(rst),
    .s_ar_addr(s_ar_addr), .s_ar_valid(s_ar_valid), .s_ar_ready(s_ar_ready),
    .s_r_data(s_r_data), .s_r_resp(s_r_resp), .s_r_valid(s_r_valid), .s_r_ready(s_r_ready),
    .m_ar_addr(m_ar_addr), .m_ar_valid(m_ar_valid), .m_ar_ready(m_ar_ready),
    .m_r_data(m_r_data), .m_r_resp(m_r_resp), .m_r_valid(m_r_valid), .m_r_ready(m_r_ready),
    .grant_idx(grant_idx), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Arbitration rule: first valid requester at or above the pointer (wrapping), or lowest index when fixed.
  function automatic int exp_winner(input logic [N-1:0] v);
    int j;
    for (int k = 0; k < N; k++) begin
`ifdef CACHE_RD_ARB_FIXED_PRIO_EN
      j = k;
`else
      j = (model_ptr + k) % N;
`endif
      if (v[j]) return j;
    end
    return -1;
  endfunction

  function automatic void note_grant(input int g);
    model_ptr = (g + 1) % N;
  endfunction

  function automatic logic [1:0] onehot(input int g);
    logic [1:0] r;
    r = 2'b00;
    r[g] = 1'b1;
    return r;
  endfunction

  // Drives the cache side from ADDR through one R handshake; leaves the arbiter in IDLE.
  task automatic complete(input logic [31:0] data, input logic [1:0] resp);
    m_ar_ready = 1'b1;
    cyc();
    m_ar_ready = 1'b0;
    m_r_data   = data;
    m_r_resp   = resp;
    m_r_valid  = 1'b1;
    s_r_ready  = 2'b11;
    cyc();
    m_r_valid  = 1'b0;
    s_r_ready  = 2'b00;
  endtask

  task automatic test_reset();
    int g;
    rst = 1'b1; s_ar_valid = 2'b11; s_ar_addr = {32'h0000_0200, 32'h0000_0100};
    m_ar_ready = 0; m_r_valid = 0; m_r_data = 0; m_r_resp = 0; s_r_ready = 0;
    cyc();
    cyc();
    checks++; if (s_ar_ready !== 2'b00) begin errors++; $display("FAIL reset_s_ar_ready: got %b want 00", s_ar_ready); end
    checks++; if (m_ar_valid !== 1'b0) begin errors++; $display("FAIL reset_m_ar_valid: got %b want 0", m_ar_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (m_ar_addr !== 32'h0) begin errors++; $display("FAIL reset_m_ar_addr: got %h want 0", m_ar_addr); end
    checks++; if (grant_idx !== 1'b0) begin errors++; $display("FAIL reset_grant_idx: got %b want 0", grant_idx); end
    checks++; if (s_r_valid !== 2'b00 || m_r_ready !== 1'b0) begin errors++; $display("FAIL reset_r: got s_r_valid=%b m_r_ready=%b want 00/0", s_r_valid, m_r_ready); end
    rst = 1'b0;
    #1;
    g = exp_winner(2'b11);
    checks++; if (s_ar_ready !== onehot(g)) begin errors++; $display("FAIL reset_first_grant: got %b want %b", s_ar_ready, onehot(g)); end
    cyc();
    s_ar_valid = 2'b00;
    checks++; if (m_ar_valid !== 1'b1 || m_ar_addr !== s_ar_addr[g*32 +: 32]) begin errors++; $display("FAIL reset_first_addr: got v=%b a=%h want 1/%h", m_ar_valid, m_ar_addr, s_ar_addr[g*32 +: 32]); end
    note_grant(g);
    complete(32'h1111_1111, 2'b00);
  endtask

  task automatic test_single();
    s_ar_addr = {32'h0000_0040, 32'h0};
    s_ar_valid = 2'b10;
    #1;
    checks++; if (s_ar_ready !== 2'b10) begin errors++; $display("FAIL single_ar_ready: got %b want 10", s_ar_ready); end
    cyc();
    s_ar_valid = 2'b00;
    note_grant(1);
    checks++; if (m_ar_addr !== 32'h40 || grant_idx !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL single_addr: got a=%h g=%b busy=%b want 40/1/1", m_ar_addr, grant_idx, busy); end
    m_r_valid = 1'b1; s_r_ready = 2'b11; #1;
    checks++; if (s_r_valid !== 2'b00 || m_r_ready !== 1'b0) begin errors++; $display("FAIL single_stray_in_addr: got s_r_valid=%b m_r_ready=%b want 00/0", s_r_valid, m_r_ready); end
    m_r_valid = 1'b0; s_r_ready = 2'b00;
    m_ar_ready = 1'b1;
    cyc();
    m_ar_ready = 1'b0;
    checks++; if (m_ar_valid !== 1'b0) begin errors++; $display("FAIL single_ar_clear: got %b want 0", m_ar_valid); end
    m_r_data = 32'hDEAD_BEEF; m_r_resp = 2'b00; m_r_valid = 1'b1; s_r_ready = 2'b10;
    #1;
    checks++; if (s_r_valid !== 2'b10) begin errors++; $display("FAIL single_r_valid: got %b want 10", s_r_valid); end
    checks++; if (s_r_data !== {2{32'hDEAD_BEEF}} || s_r_resp !== 4'b0000) begin errors++; $display("FAIL single_r_data: got %h/%b want deadbeef x2/0000", s_r_data, s_r_resp); end
    checks++; if (m_r_ready !== 1'b1) begin errors++; $display("FAIL single_m_r_ready: got %b want 1", m_r_ready); end
    cyc();
    m_r_valid = 1'b0; s_r_ready = 2'b00;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_idle: got busy=%b want 0", busy); end
  endtask

  task automatic test_round_robin();
    int g;
    int d;
    for (int t = 0; t < 6; t++) begin
      s_ar_addr = {$urandom, $urandom};
      s_ar_valid = 2'b11;
      #1;
      g = exp_winner(2'b11);
      checks++; if (s_ar_ready !== onehot(g)) begin errors++; $display("FAIL rr_grant[%0d]: got %b want %b", t, s_ar_ready, onehot(g)); end
      cyc();
      note_grant(g);
      checks++; if (grant_idx !== 1'(g) || m_ar_addr !== s_ar_addr[g*32 +: 32]) begin errors++; $display("FAIL rr_latch[%0d]: got g=%0d a=%h want %0d/%h", t, grant_idx, m_ar_addr, g, s_ar_addr[g*32 +: 32]); end
      d = $urandom_range(0, 2);
      for (int c = 0; c < d; c++) begin
        checks++; if (m_ar_valid !== 1'b1 || s_ar_ready !== 2'b00) begin errors++; $display("FAIL rr_hold[%0d]: got v=%b rdy=%b want 1/00", t, m_ar_valid, s_ar_ready); end
        cyc();
      end
      complete($urandom, 2'b00);
    end
    s_ar_valid = 2'b00;
  endtask

  task automatic test_backpressure();
    s_ar_addr = {32'h0000_0B00, 32'h0000_0A00};
    s_ar_valid = 2'b01;
    #1;
    checks++; if (s_ar_ready !== 2'b01) begin errors++; $display("FAIL bp_grant0: got %b want 01", s_ar_ready); end
    cyc();
    note_grant(0);
    s_ar_valid = 2'b10;
    m_ar_ready = 1'b1;
    cyc();
    m_ar_ready = 1'b0;
    m_r_data = 32'hCAFE_0001; m_r_resp = 2'b00; m_r_valid = 1'b1; s_r_ready = 2'b10;
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++; if (m_r_ready !== 1'b0 || busy !== 1'b1 || s_ar_ready !== 2'b00) begin errors++; $display("FAIL bp_hold[%0d]: got m_r_ready=%b busy=%b s_ar_ready=%b want 0/1/00", c, m_r_ready, busy, s_ar_ready); end
      checks++; if (s_r_valid !== 2'b01) begin errors++; $display("FAIL bp_r_valid[%0d]: got %b want 01", c, s_r_valid); end
      cyc();
    end
    s_r_ready = 2'b01;
    #1;
    checks++; if (m_r_ready !== 1'b1) begin errors++; $display("FAIL bp_release: got %b want 1", m_r_ready); end
    cyc();
    m_r_valid = 1'b0; s_r_ready = 2'b00;
    #1;
    checks++; if (s_ar_ready !== 2'b10) begin errors++; $display("FAIL bp_next_grant: got %b want 10", s_ar_ready); end
    cyc();
    note_grant(1);
    s_ar_valid = 2'b00;
    complete(32'h0, 2'b00);
  endtask

  task automatic test_reset_mid();
    s_ar_addr = {32'h0000_0D00, 32'h0000_0C00};
    s_ar_valid = 2'b01;
    cyc();
    note_grant(0);
    s_ar_valid = 2'b00;
    checks++; if (m_ar_valid !== 1'b1) begin errors++; $display("FAIL rmid_in_addr: got %b want 1", m_ar_valid); end
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    model_ptr = 0;
    checks++; if (m_ar_valid !== 1'b0 || busy !== 1'b0 || grant_idx !== 1'b0) begin errors++; $display("FAIL rmid_after: got v=%b busy=%b g=%b want 0/0/0", m_ar_valid, busy, grant_idx); end
    m_r_valid = 1'b1; s_r_ready = 2'b11; m_r_data = 32'hBAD0_BAD0;
    #1;
    checks++; if (s_r_valid !== 2'b00 || m_r_ready !== 1'b0) begin errors++; $display("FAIL rmid_stray: got s_r_valid=%b m_r_ready=%b want 00/0", s_r_valid, m_r_ready); end
    cyc();
    m_r_valid = 1'b0; s_r_ready = 2'b00;
    s_ar_valid = 2'b11;
    #1;
    checks++; if (s_ar_ready !== onehot(exp_winner(2'b11))) begin errors++; $display("FAIL rmid_ptr: got %b want %b", s_ar_ready, onehot(exp_winner(2'b11))); end
    note_grant(exp_winner(2'b11));
    cyc();
    s_ar_valid = 2'b00;
    complete(32'h0, 2'b00);
  endtask

  task automatic test_slverr();
    int g;
    s_ar_valid = 2'b10;
    g = exp_winner(2'b10);
    cyc();
    note_grant(g);
    s_ar_valid = 2'b00;
    m_ar_ready = 1'b1;
    cyc();
    m_ar_ready = 1'b0;
    m_r_data = 32'h1234_5678; m_r_resp = 2'b10; m_r_valid = 1'b1; s_r_ready = 2'b11;
    #1;
    checks++; if (s_r_resp !== 4'b1010 || s_r_data !== {2{32'h1234_5678}} || s_r_valid !== onehot(g)) begin errors++; $display("FAIL slverr: got resp=%b data=%h v=%b want 1010/12345678 x2/%b", s_r_resp, s_r_data, s_r_valid, onehot(g)); end
    cyc();
    m_r_valid = 1'b0; s_r_ready = 2'b00;
  endtask

  task automatic test_random();
    int g;
    logic [1:0] mask;
    logic [31:0] d;
    logic [1:0] rr;
    logic done;
    for (int t = 0; t < 30; t++) begin
      mask = 2'($urandom_range(0, 3));
      s_ar_addr = {$urandom, $urandom};
      s_ar_valid = mask;
      #1;
      g = exp_winner(mask);
      if (g < 0) begin
        checks++; if (s_ar_ready !== 2'b00) begin errors++; $display("FAIL rnd_none[%0d]: got %b want 00", t, s_ar_ready); end
        cyc();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rnd_idle[%0d]: got busy=%b want 0", t, busy); end
        continue;
      end
      checks++; if (s_ar_ready !== onehot(g)) begin errors++; $display("FAIL rnd_grant[%0d]: got %b want %b", t, s_ar_ready, onehot(g)); end
      cyc();
      note_grant(g);
      s_ar_valid = 2'($urandom_range(0, 3));
      checks++; if (m_ar_addr !== s_ar_addr[g*32 +: 32] || grant_idx !== 1'(g)) begin errors++; $display("FAIL rnd_latch[%0d]: got a=%h g=%0d want %h/%0d", t, m_ar_addr, grant_idx, s_ar_addr[g*32 +: 32], g); end
      m_ar_ready = 1'b1;
      cyc();
      m_ar_ready = 1'b0;
      d = $urandom;
      m_r_data = d; m_r_resp = 2'($urandom_range(0, 3)); m_r_valid = 1'b1;
      done = 1'b0;
      for (int c = 0; c < 6 && !done; c++) begin
        rr = 2'($urandom_range(0, 3));
        if (c == 5) rr[g] = 1'b1;
        s_r_ready = rr;
        #1;
        checks++; if (s_r_valid !== onehot(g) || m_r_ready !== rr[g] || s_r_data[g*32 +: 32] !== d || s_ar_ready !== 2'b00) begin errors++; $display("FAIL rnd_data[%0d.%0d]: got v=%b rdy=%b data=%h ar_rdy=%b want %b/%b/%h/00", t, c, s_r_valid, m_r_ready, s_r_data[g*32 +: 32], s_ar_ready, onehot(g), rr[g], d); end
        done = rr[g];
        cyc();
      end
      m_r_valid = 1'b0; s_r_ready = 2'b00;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rnd_return[%0d]: got busy=%b want 0", t, busy); end
    end
    s_ar_valid = 2'b00;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_reset_mid();
    test_slverr();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
